// File: rtl/pe_param_pkg.sv
// Shared types and fixed-point helpers for the parametrised PE and its array controller.
// Helpers work on 64-bit signed intermediates, so operand widths up to 32 bits are exact.
// Pure combinational functions; no state.
package pe_param_pkg;

   typedef enum logic {
      PE_WS = 1'b0,
      PE_OS = 1'b1
   } pe_mode_e;

   // Clamp a wide signed value into the signed range of a w-bit word.
   function automatic logic signed [63:0] sat_dw(input logic signed [63:0] x, input int w);
      logic signed [63:0] mx;
      logic signed [63:0] mn;
      mx = (64'sd1 <<< (w - 1)) - 64'sd1;
      mn = -mx - 64'sd1;
      if (x > mx)
         return mx;
      else if (x < mn)
         return mn;
      else
         return x;
   endfunction

   // Full-precision product rescaled back to the operand Q format.
   function automatic logic signed [63:0] fxp_mul_shift(input logic signed [63:0] a,
                                                        input logic signed [63:0] b,
                                                        input int fb);
      logic signed [63:0] p;
      p = a * b;
      return p >>> fb;
   endfunction

endpackage

// File: rtl/pe_param_if.sv
// Mesh-facing signal bundle of one PE: north/west inputs, south/east outputs, status flags.
// Pure wiring; no latency.
// No backpressure: every qualifier is a one-cycle valid strobe.
interface pe_param_if #(parameter int DATA_WIDTH = 16) ();

   logic                  pe_enabled;
   logic                  pe_mode;
   logic [DATA_WIDTH-1:0] pe_psum_in;
   logic                  pe_psum_valid_in;
   logic [DATA_WIDTH-1:0] pe_weight_in;
   logic                  pe_accept_w_in;
   logic [DATA_WIDTH-1:0] pe_input_in;
   logic                  pe_valid_in;
   logic                  pe_switch_in;
   logic                  pe_drain_in;
   logic [DATA_WIDTH-1:0] pe_psum_out;
   logic                  pe_psum_valid_out;
   logic [DATA_WIDTH-1:0] pe_weight_out;
   logic [DATA_WIDTH-1:0] pe_input_out;
   logic                  pe_valid_out;
   logic                  pe_switch_out;
   logic                  pe_drain_out;
   logic                  pe_sat_flag;
   logic                  pe_switch_err;

   // Upstream side: the array controller or a neighbouring PE.
   modport master (
      output pe_enabled, pe_mode, pe_psum_in, pe_psum_valid_in, pe_weight_in, pe_accept_w_in,
             pe_input_in, pe_valid_in, pe_switch_in, pe_drain_in,
      input  pe_psum_out, pe_psum_valid_out, pe_weight_out, pe_input_out, pe_valid_out,
             pe_switch_out, pe_drain_out, pe_sat_flag, pe_switch_err
   );

   // The PE itself.
   modport slave (
      input  pe_enabled, pe_mode, pe_psum_in, pe_psum_valid_in, pe_weight_in, pe_accept_w_in,
             pe_input_in, pe_valid_in, pe_switch_in, pe_drain_in,
      output pe_psum_out, pe_psum_valid_out, pe_weight_out, pe_input_out, pe_valid_out,
             pe_switch_out, pe_drain_out, pe_sat_flag, pe_switch_err
   );

endinterface

// File: rtl/pe_param_mac.sv
// Fixed-point multiply, rescale, saturate, then saturating add of an addend.
// Product path 0 or 1 cycle (PIPE_MUL); the add is combinational on the final-stage product.
// No backpressure: a valid operand pair always produces a product PIPE_MUL cycles later.
module fxp_mac_sat
   import pe_param_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 8,
   parameter int PIPE_MUL   = 0
) (
   input  logic                         clk_i,
   input  logic                         clr_i,
   input  logic                         vld_i,
   input  logic signed [DATA_WIDTH-1:0] a_i,
   input  logic signed [DATA_WIDTH-1:0] b_i,
   input  logic signed [DATA_WIDTH-1:0] addend_i,
   output logic signed [DATA_WIDTH-1:0] prod_o,
   output logic                         prod_vld_o,
   output logic signed [DATA_WIDTH-1:0] sum_o,
   output logic                         mul_sat_o,
   output logic                         add_sat_o
);

   logic signed [63:0]           mul_w;
   logic signed [63:0]           mul_s;
   logic signed [63:0]           add_w;
   logic signed [63:0]           add_s;
   logic signed [DATA_WIDTH-1:0] prod_c;
   logic                         mul_sat_c;
   logic signed [DATA_WIDTH-1:0] prod_q;
   logic                         mul_sat_q;
   logic                         vld_q;

   // Product: full precision, rescale, clamp to the operand width.
   always_comb begin
      mul_w     = fxp_mul_shift(64'(a_i), 64'(b_i), FRAC_BITS);
      mul_s     = sat_dw(mul_w, DATA_WIDTH);
      mul_sat_c = (mul_s != mul_w);
      prod_c    = mul_s[DATA_WIDTH-1:0];
   end

   // Optional product stage; cleared together with the rest of the PE state.
   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         prod_q    <= '0;
         mul_sat_q <= 1'b0;
         vld_q     <= 1'b0;
      end else begin
         prod_q    <= prod_c;
         mul_sat_q <= mul_sat_c;
         vld_q     <= vld_i;
      end
   end

   assign prod_o     = (PIPE_MUL != 0) ? prod_q    : prod_c;
   assign mul_sat_o  = (PIPE_MUL != 0) ? mul_sat_q : mul_sat_c;
   assign prod_vld_o = (PIPE_MUL != 0) ? vld_q     : vld_i;

   // Saturating add against the addend presented at the final stage.
   always_comb begin
      add_w     = 64'(prod_o) + 64'(addend_i);
      add_s     = sat_dw(add_w, DATA_WIDTH);
      add_sat_o = (add_s != add_w);
      sum_o     = add_s[DATA_WIDTH-1:0];
   end

endmodule

// File: rtl/pe_param.sv
// Systolic PE: runtime WS (double-buffered weight) or OS (local accumulator + drain) fixed-point MAC.
// South psum 1+PIPE_MUL cycles after valid in WS; east/south forwards and OS drain 1 cycle.
// No backpressure: mesh runs in lockstep, controller schedules drains around column traffic.
module pe_param
   import pe_param_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 8,
   parameter int PIPE_MUL   = 0
) (
   input  logic         clk,
   input  logic         rst,
   pe_param_if.slave    pe_if
);

   localparam int DW = DATA_WIDTH;

   logic                 clr;
   pe_mode_e             mode_in;
   logic                 mode_chg;
   logic                 is_os;

   pe_mode_e             mode_q,       mode_d;
   logic signed [DW-1:0] active_q,     active_d;
   logic signed [DW-1:0] shadow_q,     shadow_d;
   logic                 shadow_vld_q, shadow_vld_d;
   logic signed [DW-1:0] acc_q,        acc_d;
   logic signed [DW-1:0] psum_q,       psum_d;
   logic                 psum_vld_q,   psum_vld_d;
   logic [DW-1:0]        weight_q,     weight_d;
   logic [DW-1:0]        input_q,      input_d;
   logic                 valid_q,      valid_d;
   logic                 switch_q,     switch_d;
   logic                 drain_q,      drain_d;
   logic                 sat_q,        sat_d;
   logic                 err_q,        err_d;

   logic signed [DW-1:0] mac_b;
   logic signed [DW-1:0] mac_addend;
   logic signed [DW-1:0] prod;
   logic                 prod_vld;
   logic signed [DW-1:0] sum;
   logic                 mul_sat;
   logic                 add_sat;

   assign clr      = rst | ~pe_if.pe_enabled;
   assign mode_in  = pe_mode_e'(pe_if.pe_mode);
   assign mode_chg = (mode_in != mode_q);
   assign is_os    = (mode_in == PE_OS);

   // OS multiplies the streaming north operand into the accumulator; WS uses the held weight and north psum.
   assign mac_b      = is_os ? $signed(pe_if.pe_weight_in) : active_q;
   assign mac_addend = is_os ? acc_q : $signed(pe_if.pe_psum_in);

   fxp_mac_sat #(
      .DATA_WIDTH (DW),
      .FRAC_BITS  (FRAC_BITS),
      .PIPE_MUL   (PIPE_MUL)
   ) u_mac (
      .clk_i      (clk),
      .clr_i      (clr | mode_chg),
      .vld_i      (pe_if.pe_valid_in),
      .a_i        ($signed(pe_if.pe_input_in)),
      .b_i        (mac_b),
      .addend_i   (mac_addend),
      .prod_o     (prod),
      .prod_vld_o (prod_vld),
      .sum_o      (sum),
      .mul_sat_o  (mul_sat),
      .add_sat_o  (add_sat)
   );

   // Next state for weights, accumulator, forwards and sticky flags.
   always_comb begin
      mode_d       = mode_in;
      active_d     = active_q;
      shadow_d     = shadow_q;
      shadow_vld_d = shadow_vld_q;
      acc_d        = acc_q;
      psum_d       = '0;
      psum_vld_d   = 1'b0;
      weight_d     = '0;
      input_d      = pe_if.pe_valid_in ? pe_if.pe_input_in : input_q;
      valid_d      = pe_if.pe_valid_in;
      switch_d     = pe_if.pe_switch_in;
      drain_d      = pe_if.pe_drain_in;
      sat_d        = sat_q;
      err_d        = err_q;

      if (is_os) begin
         weight_d = pe_if.pe_valid_in ? pe_if.pe_weight_in : '0;
         if (pe_if.pe_drain_in) begin
            // Own accumulator takes the south port; any concurrent incoming psum is lost.
            psum_d     = acc_q;
            psum_vld_d = 1'b1;
            acc_d      = prod_vld ? prod : '0;
            if (prod_vld && mul_sat)
               sat_d = 1'b1;
         end else begin
            psum_d     = $signed(pe_if.pe_psum_in);
            psum_vld_d = pe_if.pe_psum_valid_in;
            if (prod_vld) begin
               acc_d = sum;
               if (mul_sat || add_sat)
                  sat_d = 1'b1;
            end
         end
      end else begin
         weight_d = pe_if.pe_accept_w_in ? pe_if.pe_weight_in : '0;
         // Promote reads the old shadow, so a same-cycle load lands behind it.
         if (pe_if.pe_switch_in) begin
            if (shadow_vld_q) begin
               active_d     = shadow_q;
               shadow_vld_d = 1'b0;
            end else begin
               err_d = 1'b1;
            end
         end
         if (pe_if.pe_accept_w_in) begin
            shadow_d     = $signed(pe_if.pe_weight_in);
            shadow_vld_d = 1'b1;
         end
         psum_d     = prod_vld ? sum : '0;
         psum_vld_d = prod_vld;
         if (prod_vld && (mul_sat || add_sat))
            sat_d = 1'b1;
      end

      // Dataflow change invalidates anything computed under the old mode.
      if (mode_chg) begin
         acc_d        = '0;
         shadow_vld_d = 1'b0;
      end
   end

   // State registers with synchronous clear on reset or disable.
   always_ff @(posedge clk) begin
      if (clr) begin
         mode_q       <= PE_WS;
         active_q     <= '0;
         shadow_q     <= '0;
         shadow_vld_q <= 1'b0;
         acc_q        <= '0;
         psum_q       <= '0;
         psum_vld_q   <= 1'b0;
         weight_q     <= '0;
         input_q      <= '0;
         valid_q      <= 1'b0;
         switch_q     <= 1'b0;
         drain_q      <= 1'b0;
         sat_q        <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         mode_q       <= mode_d;
         active_q     <= active_d;
         shadow_q     <= shadow_d;
         shadow_vld_q <= shadow_vld_d;
         acc_q        <= acc_d;
         psum_q       <= psum_d;
         psum_vld_q   <= psum_vld_d;
         weight_q     <= weight_d;
         input_q      <= input_d;
         valid_q      <= valid_d;
         switch_q     <= switch_d;
         drain_q      <= drain_d;
         sat_q        <= sat_d;
         err_q        <= err_d;
      end
   end

   assign pe_if.pe_psum_out       = psum_q;
   assign pe_if.pe_psum_valid_out = psum_vld_q;
   assign pe_if.pe_weight_out     = weight_q;
   assign pe_if.pe_input_out      = input_q;
   assign pe_if.pe_valid_out      = valid_q;
   assign pe_if.pe_switch_out     = switch_q;
   assign pe_if.pe_drain_out      = drain_q;
   assign pe_if.pe_sat_flag       = sat_q;
   assign pe_if.pe_switch_err     = err_q;

endmodule

// File: tb/tb_pe_param.sv
// Directed bench for pe_param: one PE with combinational multiply, one with the product stage.
// Both see identical stimulus; outputs are sampled 1 time unit after the rising edge.
module tb_pe_param;

   logic        clk;
   logic        rst;
   logic        en;
   logic        mode;
   logic [15:0] psum_in;
   logic        psum_vld_in;
   logic [15:0] weight_in;
   logic        accept;
   logic [15:0] in_dat;
   logic        in_vld;
   logic        sw;
   logic        drain;

   int total;
   int bad;

   pe_param_if #(.DATA_WIDTH(16)) if0 ();
   pe_param_if #(.DATA_WIDTH(16)) if1 ();

   assign if0.pe_enabled = en;          assign if1.pe_enabled = en;
   assign if0.pe_mode = mode;           assign if1.pe_mode = mode;
   assign if0.pe_psum_in = psum_in;     assign if1.pe_psum_in = psum_in;
   assign if0.pe_psum_valid_in = psum_vld_in;
   assign if1.pe_psum_valid_in = psum_vld_in;
   assign if0.pe_weight_in = weight_in; assign if1.pe_weight_in = weight_in;
   assign if0.pe_accept_w_in = accept;  assign if1.pe_accept_w_in = accept;
   assign if0.pe_input_in = in_dat;     assign if1.pe_input_in = in_dat;
   assign if0.pe_valid_in = in_vld;     assign if1.pe_valid_in = in_vld;
   assign if0.pe_switch_in = sw;        assign if1.pe_switch_in = sw;
   assign if0.pe_drain_in = drain;      assign if1.pe_drain_in = drain;

   pe_param #(.DATA_WIDTH(16), .FRAC_BITS(8), .PIPE_MUL(0)) dut0 (
      .clk   (clk),
      .rst   (rst),
      .pe_if (if0)
   );

   pe_param #(.DATA_WIDTH(16), .FRAC_BITS(8), .PIPE_MUL(1)) dut1 (
      .clk   (clk),
      .rst   (rst),
      .pe_if (if1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      psum_in = 16'h0; psum_vld_in = 1'b0; weight_in = 16'h0; accept = 1'b0;
      in_dat = 16'h0; in_vld = 1'b0; sw = 1'b0; drain = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [71:0] obs;
      en = 1'b1; mode = 1'b0;
      do_reset();
      obs = {if0.pe_psum_out, if0.pe_psum_valid_out, if0.pe_weight_out, if0.pe_input_out,
             if0.pe_valid_out, if0.pe_switch_out, if0.pe_drain_out, if0.pe_sat_flag,
             if0.pe_switch_err, 7'd0};
      total++;
      if (obs !== 72'h0) begin
         bad++; $display("FAIL reset_outputs got=%h want=0", obs);
      end
   endtask

   task automatic test_ws_basic();
      do_reset();
      accept = 1'b1; weight_in = 16'h0200;
      cyc();
      total++;
      if (if0.pe_weight_out !== 16'h0200) begin
         bad++; $display("FAIL ws_weight_fwd got=%h want=0200", if0.pe_weight_out);
      end
      accept = 1'b0; weight_in = 16'h0; sw = 1'b1;
      cyc();
      total++;
      if (if0.pe_switch_out !== 1'b1 || if0.pe_switch_err !== 1'b0 || if0.pe_weight_out !== 16'h0) begin
         bad++; $display("FAIL ws_switch got sw=%b err=%b w=%h want 1 0 0000",
                         if0.pe_switch_out, if0.pe_switch_err, if0.pe_weight_out);
      end
      sw = 1'b0; in_dat = 16'h0180; in_vld = 1'b1; psum_in = 16'h0100;
      cyc();
      total++;
      if (if0.pe_psum_out !== 16'h0400 || if0.pe_psum_valid_out !== 1'b1) begin
         bad++; $display("FAIL ws_mac got=%h v=%b want=0400 v=1", if0.pe_psum_out, if0.pe_psum_valid_out);
      end
      total++;
      if (if0.pe_input_out !== 16'h0180 || if0.pe_valid_out !== 1'b1 || if0.pe_sat_flag !== 1'b0) begin
         bad++; $display("FAIL ws_east got=%h v=%b sat=%b want=0180 1 0",
                         if0.pe_input_out, if0.pe_valid_out, if0.pe_sat_flag);
      end
      in_dat = 16'h1234; in_vld = 1'b0; psum_in = 16'h0;
      cyc();
      total++;
      if (if0.pe_psum_out !== 16'h0 || if0.pe_psum_valid_out !== 1'b0 || if0.pe_input_out !== 16'h0180) begin
         bad++; $display("FAIL ws_idle got psum=%h v=%b in=%h want 0000 0 0180",
                         if0.pe_psum_out, if0.pe_psum_valid_out, if0.pe_input_out);
      end
   endtask

   // Active weight is still 0x0200 from the previous test.
   task automatic test_ws_sat();
      in_dat = 16'h7F00; in_vld = 1'b1; psum_in = 16'h0;
      cyc();
      total++;
      if (if0.pe_psum_out !== 16'h7FFF || if0.pe_sat_flag !== 1'b1) begin
         bad++; $display("FAIL sat_pos got=%h sat=%b want=7fff 1", if0.pe_psum_out, if0.pe_sat_flag);
      end
      in_dat = 16'h8100;
      cyc();
      total++;
      if (if0.pe_psum_out !== 16'h8000) begin
         bad++; $display("FAIL sat_neg got=%h want=8000", if0.pe_psum_out);
      end
      in_dat = 16'h3000; psum_in = 16'h4000;
      cyc();
      total++;
      if (if0.pe_psum_out !== 16'h7FFF) begin
         bad++; $display("FAIL sat_add got=%h want=7fff", if0.pe_psum_out);
      end
      idle();
      cyc();
      total++;
      if (if0.pe_sat_flag !== 1'b1) begin
         bad++; $display("FAIL sat_sticky got=%b want=1", if0.pe_sat_flag);
      end
   endtask

   task automatic test_ws_switch();
      do_reset();
      accept = 1'b1; weight_in = 16'h0100;
      cyc();
      accept = 1'b0; sw = 1'b1;
      cyc();
      total++;
      if (if0.pe_switch_err !== 1'b0) begin
         bad++; $display("FAIL sw_ok_err got=%b want=0", if0.pe_switch_err);
      end
      cyc();
      total++;
      if (if0.pe_switch_err !== 1'b1) begin
         bad++; $display("FAIL sw_empty_err got=%b want=1", if0.pe_switch_err);
      end
      sw = 1'b0; in_dat = 16'h0300; in_vld = 1'b1;
      cyc();
      total++;
      if (if0.pe_psum_out !== 16'h0300) begin
         bad++; $display("FAIL sw_active_kept got=%h want=0300", if0.pe_psum_out);
      end
      do_reset();
      accept = 1'b1; weight_in = 16'h0200;
      cyc();
      weight_in = 16'h0400; sw = 1'b1;
      cyc();
      total++;
      if (if0.pe_weight_out !== 16'h0400) begin
         bad++; $display("FAIL acc_sw_wfwd got=%h want=0400", if0.pe_weight_out);
      end
      accept = 1'b0; sw = 1'b0; weight_in = 16'h0; in_dat = 16'h0100; in_vld = 1'b1;
      cyc();
      total++;
      if (if0.pe_psum_out !== 16'h0200) begin
         bad++; $display("FAIL acc_sw_old_shadow got=%h want=0200", if0.pe_psum_out);
      end
      in_vld = 1'b0; sw = 1'b1;
      cyc();
      sw = 1'b0; in_vld = 1'b1;
      cyc();
      total++;
      if (if0.pe_psum_out !== 16'h0400 || if0.pe_switch_err !== 1'b0) begin
         bad++; $display("FAIL acc_sw_new_shadow got=%h err=%b want=0400 0",
                         if0.pe_psum_out, if0.pe_switch_err);
      end
   endtask

   task automatic test_os();
      do_reset();
      mode = 1'b1;
      cyc();
      in_dat = 16'h0100; weight_in = 16'h0200; in_vld = 1'b1;
      psum_in = 16'h0055; psum_vld_in = 1'b1;
      for (int i = 0; i < 3; i++) cyc();
      total++;
      if (if0.pe_weight_out !== 16'h0200 || if0.pe_psum_out !== 16'h0055 || if0.pe_psum_valid_out !== 1'b1) begin
         bad++; $display("FAIL os_fwd got w=%h p=%h v=%b want 0200 0055 1",
                         if0.pe_weight_out, if0.pe_psum_out, if0.pe_psum_valid_out);
      end
      idle(); drain = 1'b1;
      cyc();
      total++;
      if (if0.pe_psum_out !== 16'h0600 || if0.pe_psum_valid_out !== 1'b1 || if0.pe_drain_out !== 1'b1) begin
         bad++; $display("FAIL os_drain got=%h v=%b d=%b want=0600 1 1",
                         if0.pe_psum_out, if0.pe_psum_valid_out, if0.pe_drain_out);
      end
      drain = 1'b0;
      cyc();
      total++;
      if (if0.pe_psum_valid_out !== 1'b0 || if0.pe_weight_out !== 16'h0) begin
         bad++; $display("FAIL os_drain_1cyc got v=%b w=%h want 0 0000", if0.pe_psum_valid_out, if0.pe_weight_out);
      end
      drain = 1'b1;
      cyc();
      total++;
      if (if0.pe_psum_out !== 16'h0 || if0.pe_psum_valid_out !== 1'b1) begin
         bad++; $display("FAIL os_acc_cleared got=%h v=%b want=0000 1", if0.pe_psum_out, if0.pe_psum_valid_out);
      end
      idle(); mode = 1'b0;
      cyc();
   endtask

   task automatic test_pipe();
      do_reset();
      accept = 1'b1; weight_in = 16'h0200;
      cyc();
      accept = 1'b0; weight_in = 16'h0; sw = 1'b1;
      cyc();
      sw = 1'b0; in_dat = 16'h0180; in_vld = 1'b1; psum_in = 16'h0100;
      cyc();
      total++;
      if (if1.pe_input_out !== 16'h0180 || if1.pe_valid_out !== 1'b1 || if1.pe_psum_valid_out !== 1'b0) begin
         bad++; $display("FAIL pipe_stage1 got in=%h v=%b pv=%b want 0180 1 0",
                         if1.pe_input_out, if1.pe_valid_out, if1.pe_psum_valid_out);
      end
      in_vld = 1'b0; in_dat = 16'h0;
      cyc();
      total++;
      if (if1.pe_psum_out !== 16'h0400 || if1.pe_psum_valid_out !== 1'b1 || if1.pe_valid_out !== 1'b0) begin
         bad++; $display("FAIL pipe_psum got=%h v=%b ev=%b want=0400 1 0",
                         if1.pe_psum_out, if1.pe_psum_valid_out, if1.pe_valid_out);
      end
      idle();
      cyc();
      total++;
      if (if1.pe_psum_valid_out !== 1'b0) begin
         bad++; $display("FAIL pipe_single got v=%b want=0", if1.pe_psum_valid_out);
      end
   endtask

   task automatic test_rst_mid();
      logic [31:0] obs;
      for (int k = 0; k < 2; k++) begin
         do_reset();
         mode = 1'b1;
         cyc();
         in_dat = 16'h0100; weight_in = 16'h0200; in_vld = 1'b1;
         cyc();
         cyc();
         if (k == 0) rst = 1'b1; else en = 1'b0;
         cyc();
         obs = {if0.pe_psum_out, if0.pe_psum_valid_out, if0.pe_weight_out[7:0], if0.pe_input_out[7:0]
                ^ if0.pe_input_out[15:8], 1'b0} ^ {31'd0, if0.pe_valid_out | if0.pe_drain_out |
                if0.pe_switch_out | if0.pe_sat_flag | if0.pe_switch_err};
         total++;
         if (obs !== 32'h0 || if0.pe_weight_out !== 16'h0 || if0.pe_input_out !== 16'h0) begin
            bad++; $display("FAIL clear_mid_acc k=%0d got=%h want=0", k, obs);
         end
         rst = 1'b0; en = 1'b1;
         idle(); drain = 1'b1;
         cyc();
         total++;
         if (if0.pe_psum_out !== 16'h0 || if0.pe_psum_valid_out !== 1'b1) begin
            bad++; $display("FAIL clear_drain k=%0d got=%h v=%b want=0000 1",
                            k, if0.pe_psum_out, if0.pe_psum_valid_out);
         end
      end
      idle(); mode = 1'b0;
   endtask

   initial begin
      total = 0;
      bad = 0;
      rst = 1'b1; en = 1'b1; mode = 1'b0;
      idle();
      test_reset();
      test_ws_basic();
      test_ws_sat();
      test_ws_switch();
      test_os();
      test_pipe();
      test_rst_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
